// File: rtl/fp_add_result_stage_if.sv
// Handshake bundle between the single-precision adder, the result stage and
// the writeback consumer. The slave modport is the result stage itself; the
// master modport is the environment driving adder results and the consumer.
interface fp_add_result_stage_if #(
    parameter int unsigned CNT_W = 16
);
    // Producer side (adder -> stage)
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_result;
    logic             in_overflow;
    logic             in_underflow;

    // Consumer side (stage -> writeback)
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [2:0]       out_flags;

    // Status / control
    logic [2:0]       sticky_flags;
    logic             flags_clr;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, in_result, in_overflow, in_underflow,
        output out_ready, flags_clr,
        input  in_ready, out_valid, out_result, out_flags,
        input  sticky_flags, op_count
    );

    modport slave (
        input  in_valid, in_result, in_overflow, in_underflow,
        input  out_ready, flags_clr,
        output in_ready, out_valid, out_result, out_flags,
        output sticky_flags, op_count
    );
endinterface

// File: rtl/fp_add_result_stage.sv
// Registered result stage for the single-precision adder: small in-order
// FIFO with NaN canonicalisation at capture, sticky {nv, of, uf} flags and a
// wrapping count of accepted operations. Outputs are driven only from
// registered state, so there is no combinational path from in_* to out_*.
module fp_add_result_stage #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    fp_add_result_stage_if.slave bus
);
    localparam int unsigned      PTR_W      = $clog2(DEPTH);
    localparam int unsigned      OCC_W      = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(DEPTH);
    localparam logic [31:0]      CANON_NAN  = 32'h7FC0_0000;

    typedef struct packed {
        logic [31:0] result;
        logic        nv;
        logic        of;
        logic        uf;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [OCC_W-1:0] count_q;
    logic [2:0]       sticky_q;
    logic [CNT_W-1:0] op_count_q;

    entry_t           in_entry;
    logic             in_is_nan;
    logic             in_ready_int;
    logic             out_valid_int;
    logic             push;
    logic             pop;

    // Canonicalise the incoming result and build the entry to be stored
    always_comb begin
        in_is_nan       = (bus.in_result[30:23] == 8'hFF) && (bus.in_result[22:0] != '0);
        in_entry        = '0;
        in_entry.result = in_is_nan ? CANON_NAN : bus.in_result;
        in_entry.nv     = in_is_nan;
        in_entry.of     = bus.in_overflow;
        in_entry.uf     = bus.in_underflow;
    end

    // Handshake qualification; readiness depends only on state and rst
    always_comb begin
        in_ready_int  = !rst && (count_q != FULL_COUNT);
        out_valid_int = (count_q != '0);
        push          = bus.in_valid && in_ready_int;
        pop           = out_valid_int && bus.out_ready;
    end

    // Entry storage; cleared on reset so the post-reset head reads as zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[tail_q] <= in_entry;
        end
    end

    // Head/tail pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
        end
    end

    // Occupancy tracks push minus pop
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Sticky flags accumulate at acceptance; a coincident set beats the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
        end else if (push) begin
            sticky_q <= (bus.flags_clr ? 3'b000 : sticky_q) | {in_entry.nv, in_entry.of, in_entry.uf};
        end else if (bus.flags_clr) begin
            sticky_q <= '0;
        end
    end

    // Wrapping count of accepted operations
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= '0;
        end else if (push) begin
            op_count_q <= op_count_q + CNT_W'(1);
        end
    end

    assign bus.in_ready     = in_ready_int;
    assign bus.out_valid    = out_valid_int;
    assign bus.out_result   = mem[head_q].result;
    assign bus.out_flags    = {mem[head_q].nv, mem[head_q].of, mem[head_q].uf};
    assign bus.sticky_flags = sticky_q;
    assign bus.op_count     = op_count_q;
endmodule
